spi_master_core: RTL and testbench
==================================

// Module: spi_master_core
// PURPOSE
//  SPI master engine sitting directly downstream of the Wishbone slave interface.
//  Consumes the decoded strobes (cmd / wr / rd) and the 12-bit write bus.
//  Returns a 10-bit status/data word and the bus acknowledge.
//  Shifts 8-bit frames on the SPI pins with programmable divider, CPOL, CPHA and bit order.
// PARAMETERS
//  DATA_W   8     SPI frame width in bits (din[7:0] holds the received frame)
//  DIV_W    8     width of the SCLK divider field
// PORTS
//  clk       in   1   system clock; sole clock domain
//  rst       in   1   synchronous, active-high reset
//  sel       in   1   wb_stb & wb_cyc from the bus side; qualifies cmd/wr/rd
//  dout      in   12  write bus from the interface (settings or tx byte)
//  cmd       in   1   settings-register access (address decode & we)
//  wr        in   1   data-register write
//  rd        in   1   data-register read
//  din       out  10  {busy, rx_valid, rx_data[7:0]} to the interface
//  ack       out  1   bus acknowledge to the interface
//  spi_sclk  out  1   SPI clock
//  spi_mosi  out  1   SPI master-out
//  spi_miso  in   1   SPI master-in
//  spi_ss_n  out  1   active-low slave select
//  done      out  1   1-cycle pulse when a frame completes
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): FSM=IDLE; settings=12'h004; rx_data=0; rx_valid=0;
//   ack=0; done=0; spi_sclk=0; spi_mosi=0; spi_ss_n=1; din=10'h000.
//  Settings reg: [7:0] div, [8] CPOL, [9] CPHA, [10] LSB-first, [11] SS hold.
//   SCLK half-period = div+1 clk cycles; div=0 gives clk/2.
//  Request: req = sel & (cmd|wr|rd). ack is registered: ack <= req & ~ack & ~stall.
//   Yields a 1-cycle ack pulse, 1 cycle after req is seen; ack is never asserted twice per access.
//  stall = (cmd|wr) & (FSM!=IDLE): ack is withheld (wait states) until FSM returns to IDLE.
//   The access is then taken and acked normally. rd never stalls.
//  cmd taken: settings <= dout[11:0] on the ack cycle.
//  wr taken: tx shift reg <= dout[7:0] (dout[11:8] ignored); FSM IDLE->LEAD on the ack cycle.
//  rd taken: rx_valid cleared on the ack cycle. din shows pre-clear value during ack.
//  din is driven continuously from registers: din = {busy, rx_valid, rx_data}.
//  busy = (FSM != IDLE).
//  FSM: IDLE -> LEAD (1 half-period, ss_n=0, sclk=CPOL) -> SHIFT (2*DATA_W half-periods,
//   sclk toggles at each half-period end) -> TRAIL (1 half-period, sclk=CPOL) -> IDLE.
//  Divider counter runs 0..div only outside IDLE; it restarts at 0 on each state entry.
//  Accept to busy-low latency = (2*DATA_W+2)*(div+1) cycles, i.e. 18*(div+1) for 8 bits.
//  CPHA=0: first bit on mosi at LEAD entry; sample on leading SCLK edges; shift on trailing edges.
//  CPHA=1: shift on leading edges; sample on trailing edges.
//  Bit order: MSB first unless settings[10]=1.
//  On TRAIL->IDLE: rx_data <= shifted frame; rx_valid <= 1 (overwrite, no overrun flag); done=1.
//   Same-cycle rd ack and frame end: the set wins.
//  spi_ss_n: 0 from LEAD through TRAIL. In IDLE, ss_n = ~settings[11].
//  spi_sclk in IDLE = settings[8]; a CPOL change via cmd applies immediately (only possible in IDLE).
//  spi_mosi holds the last driven bit in IDLE.
//  rst mid-transfer: everything returns to reset values next edge; the partial frame is discarded.
// TESTING
//  1. Reset -> din=0x000, ack=0, sclk=0, ss_n=1, mosi=0, done=0.
//  2. cmd 0x003; wr 0x0A5, miso tied to mosi -> 8 rising sclk edges, ss_n low 72 cycles;
//     done pulse; rd -> din=0x1A5; second rd -> din=0x0A5.
//  3. wr 0x055 then wr 0x0F0 while busy -> second ack held until IDLE; second frame starts
//     on that ack; both frames appear on mosi intact.
//  4. cmd 0x300 (div 0, CPOL=1, CPHA=1); wr 0x000 with slave driving 0x3C -> sclk idles high;
//     rx_data=0x3C; frame takes 18 cycles.
//  5. cmd 0x404 (LSB first); wr 0x001 -> first mosi bit=1, remaining bits 0.
//  6. rst during SHIFT of bit 3 -> next cycle ss_n=1, sclk=0, busy=0, rx_valid=0;
//     a new wr runs normally.

Source files
------------

// File: rtl/spi_master_core_if.sv
// spi_master_core_if: bus-side strobes, write data, read data and acknowledge for the SPI master
interface spi_master_core_if #(
  parameter int DATA_W = 8
);
  logic              sel;
  logic              cmd;
  logic              wr;
  logic              rd;
  logic [11:0]       dout;
  logic [DATA_W+1:0] din;
  logic              ack;
  modport master (output sel, cmd, wr, rd, dout, input din, ack);
  modport slave  (input sel, cmd, wr, rd, dout, output din, ack);
endinterface

// File: rtl/spi_master_core.sv
// spi_master_core: SPI master engine with programmable divider, CPOL, CPHA, bit order and stalling bus ack
module spi_master_core #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  spi_master_core_if.slave bus,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic             spi_ss_n,
  output logic             done
);
  localparam int HW = $clog2(2 * DATA_W);
  localparam logic [HW-1:0] LAST = HW'(2 * DATA_W - 1);
  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;
  state_t            st_q;
  logic [11:0]       set_q, set_d;
  logic [DIV_W-1:0]  cnt_q;
  logic [HW-1:0]     hp_q;
  logic [DATA_W-1:0] tx_q, rx_sh_q, rx_q, wd;
  logic              rxv_q, ack_q, sclk_q, mosi_q, ss_n_q, done_q;
  logic              busy, req, stall, take_cmd, take_wr, take_rd;
  logic              hp_end, lsb, cpha, shift_ev, sample_ev;
  assign busy      = st_q != IDLE;
  assign req       = bus.sel && (bus.cmd || bus.wr || bus.rd);
  assign stall     = (bus.cmd || bus.wr) && busy;
  assign take_cmd  = ack_q && bus.sel && bus.cmd;
  assign take_wr   = ack_q && bus.sel && bus.wr;
  assign take_rd   = ack_q && bus.sel && bus.rd;
  assign set_d     = take_cmd ? bus.dout : set_q;
  assign lsb       = set_q[10];
  assign cpha      = set_q[9];
  assign hp_end    = cnt_q == set_q[DIV_W-1:0];
  assign shift_ev  = st_q == SHIFT && hp_end && (cpha ? !hp_q[0] : hp_q[0] && hp_q != LAST);
  assign sample_ev = st_q == SHIFT && hp_end && (cpha == hp_q[0]);
  assign wd        = bus.dout[DATA_W-1:0];
  assign bus.din   = {busy, rxv_q, rx_q};
  assign bus.ack   = ack_q;
  assign spi_sclk  = sclk_q;
  assign spi_mosi  = mosi_q;
  assign spi_ss_n  = ss_n_q;
  assign done      = done_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      set_q   <= 12'h004;
      cnt_q   <= '0;
      hp_q    <= '0;
      tx_q    <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      rxv_q   <= 1'b0;
      ack_q   <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      ack_q  <= req && !ack_q && !stall;
      set_q  <= set_d;
      done_q <= 1'b0;
      cnt_q  <= (!busy || hp_end) ? '0 : cnt_q + 1'b1;
      if (take_rd) rxv_q <= 1'b0;
      if (sample_ev) rx_sh_q <= lsb ? {spi_miso, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], spi_miso};
      if (shift_ev) begin
        mosi_q <= lsb ? tx_q[0] : tx_q[DATA_W-1];
        tx_q   <= lsb ? tx_q >> 1 : tx_q << 1;
      end
      case (st_q)
        IDLE: begin
          sclk_q <= set_d[8];
          ss_n_q <= !set_d[11] && !take_wr;
          hp_q   <= '0;
          if (take_wr) begin
            st_q <= LEAD;
            tx_q <= cpha ? wd : (lsb ? wd >> 1 : wd << 1);
            if (!cpha) mosi_q <= lsb ? wd[0] : wd[DATA_W-1];
          end
        end
        LEAD: if (hp_end) st_q <= SHIFT;
        SHIFT: if (hp_end) begin
          sclk_q <= !sclk_q;
          hp_q   <= hp_q + 1'b1;
          if (hp_q == LAST) st_q <= TRAIL;
        end
        TRAIL: if (hp_end) begin
          st_q   <= IDLE;
          rx_q   <= rx_sh_q;
          rxv_q  <= 1'b1;
          done_q <= 1'b1;
          ss_n_q <= !set_q[11];
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_core.sv
// tb_spi_master_core: scoreboard bench for spi_master_core with loopback and CPHA=1 slave model
module tb_spi_master_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spi_master_core_if #(.DATA_W(8)) bus();
  logic spi_sclk, spi_mosi, spi_miso, spi_ss_n, done;
  logic miso_s = 1'b0;
  logic loop = 1'b1;
  logic b_cpol = 1'b0, b_cpha = 1'b0, b_lsb = 1'b0;
  logic [7:0] sl_tx = 8'h00;
  logic [7:0] mon_byte = 8'h00;
  logic prev_sclk = 1'b0;
  int sl_idx = 0, sclk_edges = 0, edge_base = 0, low_cnt = 0;
  int n_cmp = 0, n_bad = 0;
  logic [9:0] exp_din_q[$];
  logic [7:0] exp_frame_q[$];
  int exp_len_q[$];
  assign spi_miso = loop ? spi_mosi : miso_s;
  spi_master_core dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_ss_n (spi_ss_n),
    .done     (done)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask
  task automatic xfer(input logic c, input logic w, input logic r, input logic [11:0] d,
                      output int waited, output logic [9:0] din_ack);
    @(negedge clk);
    bus.sel = 1'b1; bus.cmd = c; bus.wr = w; bus.rd = r; bus.dout = d;
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!bus.ack && waited < 500);
    din_ack = bus.din;
    if (!bus.ack) flag("ack_timeout");
    else begin
      @(posedge clk); #1;
    end
    bus.sel = 1'b0; bus.cmd = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0;
  endtask
  task automatic do_cmd(input logic [11:0] d);
    int w; logic [9:0] x;
    xfer(1'b1, 1'b0, 1'b0, d, w, x);
  endtask
  task automatic do_wr(input logic [7:0] d, input logic [7:0] exp_mosi, input int exp_len);
    int w; logic [9:0] x;
    exp_frame_q.push_back(exp_mosi);
    exp_len_q.push_back(exp_len);
    xfer(1'b0, 1'b1, 1'b0, {4'hF, d}, w, x);
  endtask
  task automatic do_rd(input logic [9:0] exp);
    int w; logic [9:0] x;
    exp_din_q.push_back(exp);
    xfer(1'b0, 1'b0, 1'b1, 12'h000, w, x);
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.din[9] && n < 2000);
    if (bus.din[9]) flag("idle_timeout");
  endtask
  initial forever begin
    @(spi_sclk or spi_ss_n);
    if (spi_ss_n) sl_idx = 0;
    else if (spi_sclk !== prev_sclk) begin
      sclk_edges++;
      if ((spi_sclk != b_cpol) ^ b_cpha) mon_byte = b_lsb ? {spi_mosi, mon_byte[7:1]} : {mon_byte[6:0], spi_mosi};
      if ((spi_sclk != b_cpol) && b_cpha && sl_idx < 8) begin
        miso_s = sl_tx[3'(7 - sl_idx)];
        sl_idx++;
      end
    end
    prev_sclk = spi_sclk;
  end
  initial forever begin
    @(posedge clk); #1;
    if (rst) begin
      edge_base = sclk_edges;
      low_cnt = 0;
    end else begin
      if (bus.ack && bus.rd) begin
        if (exp_din_q.size() == 0) flag("rd_ack_without_expectation");
        else chk("rd_din", 32'(bus.din), 32'(exp_din_q.pop_front()));
      end
      if (done) begin
        if (exp_frame_q.size() == 0) flag("done_without_expectation");
        else begin
          chk("frame_mosi", 32'(mon_byte), 32'(exp_frame_q.pop_front()));
          chk("frame_sclk_edges", 32'(sclk_edges - edge_base), 32'd16);
          chk("frame_ss_low_cycles", 32'(low_cnt), 32'(exp_len_q.pop_front()));
        end
        edge_base = sclk_edges;
        low_cnt = 0;
      end
      if (!spi_ss_n) low_cnt++;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    int w;
    logic [9:0] x;
    bus.sel = 1'b0; bus.cmd = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0; bus.dout = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_din", 32'(bus.din), 32'h000);
    chk("reset_ack", 32'(bus.ack), 32'h0);
    chk("reset_sclk", 32'(spi_sclk), 32'h0);
    chk("reset_ss_n", 32'(spi_ss_n), 32'h1);
    chk("reset_mosi", 32'(spi_mosi), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_cmd(12'h003);
    exp_frame_q.push_back(8'hA5);
    exp_len_q.push_back(72);
    xfer(1'b0, 1'b1, 1'b0, 12'h0A5, w, x);
    chk("wr_idle_ack_latency", 32'(w), 32'd1);
    chk("lead_first_mosi_msb", 32'(spi_mosi), 32'h1);
    chk("lead_ss_n", 32'(spi_ss_n), 32'h0);
    wait_idle();
    do_rd(10'h1A5);
    do_rd(10'h0A5);
    do_wr(8'h55, 8'h55, 72);
    exp_frame_q.push_back(8'hF0);
    exp_len_q.push_back(72);
    xfer(1'b0, 1'b1, 1'b0, 12'h0F0, w, x);
    chk("stalled_wr_wait_cycles", 32'(w), 32'd73);
    chk("stalled_wr_busy_at_ack", 32'(x[9]), 32'h0);
    chk("second_frame_started", 32'(bus.din[9]), 32'h1);
    wait_idle();
    do_rd(10'h1F0);
    do_cmd(12'h300);
    chk("cpol1_idle_sclk", 32'(spi_sclk), 32'h1);
    b_cpol = 1'b1; b_cpha = 1'b1; loop = 1'b0; sl_tx = 8'h3C;
    do_wr(8'h00, 8'h00, 18);
    wait_idle();
    do_rd(10'h13C);
    loop = 1'b1;
    do_cmd(12'h404);
    b_cpol = 1'b0; b_cpha = 1'b0; b_lsb = 1'b1;
    chk("cpol0_idle_sclk", 32'(spi_sclk), 32'h0);
    do_wr(8'h01, 8'h01, 90);
    chk("lsb_first_mosi", 32'(spi_mosi), 32'h1);
    wait_idle();
    chk("lsb_rx_din", 32'(bus.din), 32'h101);
    xfer(1'b0, 1'b1, 1'b0, 12'h0C3, w, x);
    repeat (38) @(posedge clk);
    #1;
    chk("midframe_busy", 32'(bus.din[9]), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_ss_n", 32'(spi_ss_n), 32'h1);
    chk("abort_sclk", 32'(spi_sclk), 32'h0);
    chk("abort_din", 32'(bus.din), 32'h000);
    chk("abort_mosi", 32'(spi_mosi), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    b_cpol = 1'b0; b_cpha = 1'b0; b_lsb = 1'b0;
    do_wr(8'h3C, 8'h3C, 90);
    wait_idle();
    do_rd(10'h13C);
    repeat (4) @(posedge clk);
    chk("queues_drained", 32'(exp_din_q.size() + exp_frame_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
